zrle_gen: RTL and testbench



---
 rtl/ebpc_pkg.sv | 21 ++
 rtl/zrle_bit_packer.sv | 83 ++++++++
 rtl/zrle_gen.sv | 192 +++++++++++++++++++
 tb/tb_zrle_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebpc_pkg.sv
// -----------------------------------------------------------------------------
// ebpc_pkg
// Shared definitions for the EBPC encoder path.
//   DATA_W            default output word width of the ZRLE stage
//   LOG_MAX_ZRLE_LEN  default run-length field width (MAX_RUN = 2**value)
//   zrle_state_t      state encoding of the zero run-length encoder
// -----------------------------------------------------------------------------
package ebpc_pkg;

    localparam int unsigned DATA_W           = 8;
    localparam int unsigned LOG_MAX_ZRLE_LEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FULL,
        FLUSH_RUN,
        FLUSH
    } zrle_state_t;

endpackage

// File: rtl/zrle_bit_packer.sv
// -----------------------------------------------------------------------------
// zrle_bit_packer
// MSB-first bit accumulator for the zero run-length encoder. Owns the
// 2*DATA_W staging register and its fill count; codes are ORed in directly
// below the bits already held, and the upper word can be shifted out.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   code_i         code value, right-aligned, len_i bits significant
//   len_i          code length in bits (0 appends nothing)
//   append_i       place code_i after the current fill
//   shift_i        drop the upper DATA_W bits (applied before an append)
//   clear_i        discard everything (end of stream)
//   data_o         upper DATA_W bits of the staging register
//   fill_o         number of valid bits, counted from the MSB
//   fill_nxt_o     fill count after this cycle's shift/append
// -----------------------------------------------------------------------------
module zrle_bit_packer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CODE_W = 4,
    parameter int unsigned LEN_W  = 3,
    parameter int unsigned FILL_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [CODE_W-1:0] code_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              append_i,
    input  logic              shift_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] data_o,
    output logic [FILL_W-1:0] fill_o,
    output logic [FILL_W-1:0] fill_nxt_o
);

    localparam int unsigned       REG_W    = 2 * DATA_W;
    localparam logic [FILL_W-1:0] WORD_LEN = FILL_W'(DATA_W);
    localparam logic [FILL_W-1:0] REG_LEN  = FILL_W'(REG_W);

    logic [REG_W-1:0]  r_stage;
    logic [FILL_W-1:0] r_fill;
    logic [REG_W-1:0]  w_base;
    logic [REG_W-1:0]  w_code_ext;
    logic [REG_W-1:0]  w_stage_nxt;
    logic [FILL_W-1:0] w_off;
    logic [FILL_W-1:0] w_len_ext;
    logic [FILL_W-1:0] w_pos;

    // A shift and an append may coincide: the code lands behind the bits
    // that remain after the upper word leaves.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; this
        // block assigns all of them unconditionally, so no latch is inferred.
        w_base      = shift_i ? (r_stage << DATA_W) : r_stage;
        w_off       = shift_i ? (r_fill - WORD_LEN) : r_fill;
        w_len_ext   = append_i ? FILL_W'(len_i) : '0;
        // LSB position of the code so that its MSB sits at bit (REG_W-1-w_off).
        w_pos       = REG_LEN - w_off - w_len_ext;
        w_code_ext  = REG_W'(code_i);
        w_stage_nxt = append_i ? (w_base | (w_code_ext << w_pos)) : w_base;
        fill_nxt_o  = w_off + w_len_ext;
    end

    // NOTE: the staging register is reset (not left undefined) because
    // data_o must read zero out of reset and a mid-stream reset must discard
    // every pending bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state is assigned with <= so every register
            // samples the pre-edge values.
            r_stage <= '0;
            r_fill  <= '0;
        end else if (clear_i) begin
            r_stage <= '0;
            r_fill  <= '0;
        end else begin
            r_stage <= w_stage_nxt;
            r_fill  <= fill_nxt_o;
        end
    end

    assign data_o = r_stage[REG_W-1 -: DATA_W];
    assign fill_o = r_fill;

endmodule

// File: rtl/zrle_gen.sv
// -----------------------------------------------------------------------------
// zrle_gen
// Zero run-length encoder. One significance symbol per handshake; zero runs
// of up to 2**RUN_W are compressed, ones pass as single bits, and a raw
// bypass mode emits each symbol as one bit. Codes are packed MSB-first into
// DATA_W-bit words; the final word of a stream carries last_o and the count
// of valid MSBs.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   is_one_i, flush_i      symbol value, last symbol of the stream
//   bypass_i               raw mode, sampled on the first symbol of a stream
//   vld_i / rdy_o          input handshake
//   data_o, last_o         output word (MSB first), final-word marker
//   last_bits_o            valid MSBs in data_o (DATA_W except final word)
//   vld_o / rdy_i          output handshake
//   idle_o                 no stream in progress
// -----------------------------------------------------------------------------
module zrle_gen #(
    parameter int unsigned DATA_W = ebpc_pkg::DATA_W,
    parameter int unsigned RUN_W  = ebpc_pkg::LOG_MAX_ZRLE_LEN
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    is_one_i,
    input  logic                    flush_i,
    input  logic                    bypass_i,
    input  logic                    vld_i,
    output logic                    rdy_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    last_o,
    output logic [$clog2(DATA_W):0] last_bits_o,
    output logic                    vld_o,
    input  logic                    rdy_i,
    output logic                    idle_o
);

    import ebpc_pkg::*;

    localparam int unsigned       CODE_W   = RUN_W + 2;
    localparam int unsigned       LEN_W    = $clog2(CODE_W + 1);
    localparam int unsigned       FILL_W   = $clog2(2 * DATA_W) + 1;
    localparam int unsigned       LB_W     = $clog2(DATA_W) + 1;
    localparam logic [FILL_W-1:0] WORD_LEN = FILL_W'(DATA_W);
    localparam logic [LB_W-1:0]   WORD_LB  = LB_W'(DATA_W);
    localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0]  RUN_LAST = '1;           // MAX_RUN-1
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_RUN  = LEN_W'(RUN_W + 1);
    localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(RUN_W + 2);

    zrle_state_t       r_state;
    zrle_state_t       w_state_acc;
    logic [RUN_W-1:0]  r_run;
    logic              r_bypass;
    logic [RUN_W-1:0]  w_run_m1;
    logic [RUN_W-1:0]  w_run_nxt;
    logic [CODE_W-1:0] w_code;
    logic [LEN_W-1:0]  w_len;
    logic [FILL_W-1:0] w_fill;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              w_accept;
    logic              w_mode;
    logic              w_append;
    logic              w_shift;
    logic              w_clear;

    // Output decode from registered state and fill.
    assign rdy_o       = (r_state == IDLE) || (r_state == FILL) ||
                         ((r_state == FULL) && rdy_i);
    assign vld_o       = (r_state == FULL) || (r_state == FLUSH);
    assign last_o      = (r_state == FLUSH) && (w_fill <= WORD_LEN);
    assign last_bits_o = last_o ? w_fill[LB_W-1:0] : (vld_o ? WORD_LB : '0);
    assign idle_o      = (r_state == IDLE) && !vld_i;

    assign w_accept = vld_i && rdy_o;
    // The mode of a new stream comes straight from the input on its first symbol.
    assign w_mode   = (r_state == IDLE) ? bypass_i : r_bypass;
    assign w_run_m1 = r_run - RUN_ONE;
    assign w_append = w_accept || (r_state == FLUSH_RUN);
    assign w_shift  = vld_o && rdy_i;
    assign w_clear  = last_o && rdy_i;

    // Code selection for the accepted symbol, or the pending-run code while
    // in FLUSH_RUN.
    always_comb begin
        w_code    = '0;
        w_len     = '0;
        w_run_nxt = r_run;
        if (r_state == FLUSH_RUN) begin
            w_code = {2'b00, w_run_m1};
            w_len  = LEN_RUN;
        end else if (w_accept) begin
            if (w_mode) begin
                w_code = CODE_W'(is_one_i);
                w_len  = LEN_ONE;
            end else if (is_one_i) begin
                if (r_run == '0) begin
                    w_code = CODE_W'(1'b1);
                    w_len  = LEN_ONE;
                end else begin
                    w_code = {1'b0, w_run_m1, 1'b1};
                    w_len  = LEN_FULL;
                end
                w_run_nxt = '0;
            end else if (r_run == RUN_LAST) begin
                // This zero completes a maximal run.
                w_code    = {2'b00, RUN_LAST};
                w_len     = LEN_RUN;
                w_run_nxt = '0;
            end else begin
                w_run_nxt = r_run + RUN_ONE;
            end
        end
    end

    // Destination after accepting a symbol.
    always_comb begin
        if (flush_i) begin
            w_state_acc = (!w_mode && (w_run_nxt != '0)) ? FLUSH_RUN : FLUSH;
        end else if (w_fill_nxt >= WORD_LEN) begin
            w_state_acc = FULL;
        end else begin
            w_state_acc = FILL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_run    <= '0;
            r_bypass <= 1'b0;
        end else begin
            if (w_accept) begin
                r_run <= w_run_nxt;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_bypass <= bypass_i;
                        r_state  <= w_state_acc;
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        r_state <= w_state_acc;
                    end
                end
                FULL: begin
                    // A drained word with no new symbol keeps the stream open
                    // in FILL so its mode and pending run survive.
                    if (rdy_i) begin
                        if (w_accept) begin
                            r_state <= w_state_acc;
                        end else begin
                            r_state <= (w_fill_nxt >= WORD_LEN) ? FULL : FILL;
                        end
                    end
                end
                FLUSH_RUN: begin
                    r_run   <= '0;
                    r_state <= FLUSH;
                end
                FLUSH: begin
                    if (w_clear) begin
                        r_state  <= IDLE;
                        r_bypass <= 1'b0;
                        r_run    <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    zrle_bit_packer #(
        .DATA_W (DATA_W),
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W),
        .FILL_W (FILL_W)
    ) u_packer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .code_i     (w_code),
        .len_i      (w_len),
        .append_i   (w_append),
        .shift_i    (w_shift),
        .clear_i    (w_clear),
        .data_o     (data_o),
        .fill_o     (w_fill),
        .fill_nxt_o (w_fill_nxt)
    );

endmodule

// File: tb/tb_zrle_gen.sv
// -----------------------------------------------------------------------------
// tb_zrle_gen
// Self-checking bench for zrle_gen (DATA_W=8, RUN_W=2): directed scenarios
// with fixed expected words, plus randomized streams compared against a
// bit-string reference model of the code alphabet.
// -----------------------------------------------------------------------------
module tb_zrle_gen;

    localparam int DATA_W  = 8;
    localparam int RUN_W   = 2;
    localparam int MAX_RUN = 1 << RUN_W;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [3:0] bits;
    } word_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       is_one_i;
    logic       flush_i;
    logic       bypass_i;
    logic       vld_i;
    logic       rdy_o;
    logic [7:0] data_o;
    logic       last_o;
    logic [3:0] last_bits_o;
    logic       vld_o;
    logic       rdy_i;
    logic       idle_o;

    int    n_vec = 0;
    int    n_err = 0;
    bit    sym_q[$];
    word_t got_q[$];
    word_t exp_q[$];
    int    hold_viol;
    bit    timeout;

    always #5 clk_i = ~clk_i;

    zrle_gen #(.DATA_W(DATA_W), .RUN_W(RUN_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .is_one_i    (is_one_i),
        .flush_i     (flush_i),
        .bypass_i    (bypass_i),
        .vld_i       (vld_i),
        .rdy_o       (rdy_o),
        .data_o      (data_o),
        .last_o      (last_o),
        .last_bits_o (last_bits_o),
        .vld_o       (vld_o),
        .rdy_i       (rdy_i),
        .idle_o      (idle_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: build the code bit string from the alphabet rules, then cut
    // it into 8-bit words.
    task automatic build_model(input bit byp);
        bit    q[$];
        int    zeros;
        int    nw;
        word_t w;
        zeros = 0;
        exp_q.delete();
        foreach (sym_q[i]) begin
            if (byp) begin
                q.push_back(sym_q[i]);
            end else if (sym_q[i]) begin
                if (zeros > 0) begin
                    q.push_back(1'b0);
                    for (int b = RUN_W - 1; b >= 0; b--) q.push_back(1'((zeros - 1) >> b));
                end
                q.push_back(1'b1);
                zeros = 0;
            end else begin
                zeros++;
                if (zeros == MAX_RUN) begin
                    q.push_back(1'b0);
                    for (int b = RUN_W - 1; b >= 0; b--) q.push_back(1'((MAX_RUN - 1) >> b));
                    zeros = 0;
                end
            end
        end
        if (zeros > 0) begin
            q.push_back(1'b0);
            for (int b = RUN_W - 1; b >= 0; b--) q.push_back(1'((zeros - 1) >> b));
        end
        nw = (q.size() + 7) / 8;
        for (int k = 0; k < nw; k++) begin
            w.data = '0;
            for (int j = 0; j < 8; j++) if (8 * k + j < q.size()) w.data[7 - j] = q[8 * k + j];
            w.last = (k == nw - 1);
            w.bits = w.last ? 4'(q.size() - 8 * k) : 4'd8;
            exp_q.push_back(w);
        end
    endtask

    // Drives sym_q as one stream (flush on the last symbol) with random input
    // gaps and output stalls, collecting handshaken words into got_q.
    task automatic run_stream(input bit byp, input int gap_pct, input int stall_pct);
        int         idx;
        int         cyc;
        bit         done;
        bit         hold;
        logic [7:0] hd;
        logic       hl;
        logic [3:0] hb;
        word_t      w;
        idx = 0; cyc = 0; done = 0; hold = 0;
        hd = '0; hl = 1'b0; hb = '0;
        got_q.delete();
        hold_viol = 0;
        timeout = 0;
        while (!done && cyc < 3000) begin
            rdy_i = ($urandom_range(99) >= stall_pct);
            if (idx < sym_q.size() && $urandom_range(99) >= gap_pct) begin
                vld_i    = 1'b1;
                is_one_i = sym_q[idx];
                flush_i  = (idx == sym_q.size() - 1);
                bypass_i = (idx == 0) ? byp : 1'($urandom);
            end else begin
                vld_i    = 1'b0;
                is_one_i = 1'($urandom);
                flush_i  = 1'($urandom);
                bypass_i = 1'($urandom);
            end
            #1;
            if (hold && (vld_o !== 1'b1 || data_o !== hd || last_o !== hl || last_bits_o !== hb))
                hold_viol++;
            hold = 0;
            if (vld_o === 1'b1) begin
                if (rdy_i) begin
                    w.data = data_o; w.last = last_o; w.bits = last_bits_o;
                    got_q.push_back(w);
                    if (last_o === 1'b1) done = 1;
                end else begin
                    hold = 1; hd = data_o; hl = last_o; hb = last_bits_o;
                end
            end
            if (vld_i && rdy_o === 1'b1) idx++;
            tick();
            cyc++;
        end
        if (!done) timeout = 1;
        vld_i = 1'b0; flush_i = 1'b0; rdy_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; vld_i = 1'b0; is_one_i = 1'b0; flush_i = 1'b0;
        bypass_i = 1'b0; rdy_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_vec++; if (vld_o !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", vld_o); end
        n_vec++; if (last_o !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b want 0", last_o); end
        n_vec++; if (last_bits_o !== 4'd0) begin n_err++; $display("FAIL rst_bits: got %0d want 0", last_bits_o); end
        n_vec++; if (data_o !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", data_o); end
        n_vec++; if (rdy_o !== 1'b1) begin n_err++; $display("FAIL rst_rdy: got %b want 1", rdy_o); end
        n_vec++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", idle_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        n_vec++; if (idle_o !== 1'b1 || vld_o !== 1'b0) begin
            n_err++; $display("FAIL post_rst: idle %b vld %b want 1 0", idle_o, vld_o);
        end
    endtask

    task automatic test_basic();
        sym_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_stream(1'b0, 0, 0);
        n_vec++; if (timeout !== 1'b0 || got_q.size() != 1) begin
            n_err++; $display("FAIL basic_words: got %0d words (timeout %b) want 1", got_q.size(), timeout);
        end
        if (got_q.size() > 0) begin
            n_vec++; if (got_q[0].data !== 8'h98) begin n_err++; $display("FAIL basic_data: got %h want 98", got_q[0].data); end
            n_vec++; if (got_q[0].last !== 1'b1) begin n_err++; $display("FAIL basic_last: got %b want 1", got_q[0].last); end
            n_vec++; if (got_q[0].bits !== 4'd5) begin n_err++; $display("FAIL basic_bits: got %0d want 5", got_q[0].bits); end
        end
        n_vec++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL basic_idle: got %b want 1", idle_o); end
    endtask

    task automatic test_zero_run();
        sym_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_stream(1'b0, 0, 0);
        n_vec++; if (timeout !== 1'b0 || got_q.size() != 1) begin
            n_err++; $display("FAIL zrun_words: got %0d words (timeout %b) want 1", got_q.size(), timeout);
        end
        if (got_q.size() > 0) begin
            n_vec++; if (got_q[0].data !== 8'h60) begin n_err++; $display("FAIL zrun_data: got %h want 60", got_q[0].data); end
            n_vec++; if (got_q[0].last !== 1'b1 || got_q[0].bits !== 4'd6) begin
                n_err++; $display("FAIL zrun_tail: got last %b bits %0d want 1 6", got_q[0].last, got_q[0].bits);
            end
        end
    endtask

    task automatic test_bypass();
        sym_q = '{1'b0, 1'b0, 1'b1, 1'b0};
        run_stream(1'b1, 0, 0);
        n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL byp_words: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_vec++; if (got_q[0].data !== 8'h20 || got_q[0].last !== 1'b1 || got_q[0].bits !== 4'd4) begin
                n_err++; $display("FAIL byp_word: got %h/%b/%0d want 20/1/4", got_q[0].data, got_q[0].last, got_q[0].bits);
            end
        end
        sym_q = '{1'b1, 1'b1};
        run_stream(1'b0, 0, 0);
        n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL nobyp_words: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_vec++; if (got_q[0].data !== 8'hC0 || got_q[0].last !== 1'b1 || got_q[0].bits !== 4'd2) begin
                n_err++; $display("FAIL nobyp_word: got %h/%b/%0d want c0/1/2", got_q[0].data, got_q[0].last, got_q[0].bits);
            end
        end
    endtask

    task automatic test_backpressure();
        rdy_i = 1'b0; bypass_i = 1'b0; flush_i = 1'b0; is_one_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vld_i = 1'b1;
            tick();
        end
        flush_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (vld_o !== 1'b1 || data_o !== 8'hFF || last_o !== 1'b0 || last_bits_o !== 4'd8 || rdy_o !== 1'b0) begin
                n_err++; $display("FAIL bp_hold%0d: got vld %b data %h last %b bits %0d rdy %b want 1 ff 0 8 0",
                                  i, vld_o, data_o, last_o, last_bits_o, rdy_o);
            end
            tick();
        end
        rdy_i = 1'b1;
        #1;
        n_vec++; if (rdy_o !== 1'b1) begin n_err++; $display("FAIL bp_rdy: got %b want 1", rdy_o); end
        tick();
        vld_i = 1'b0; flush_i = 1'b0;
        #1;
        n_vec++; if (vld_o !== 1'b1 || data_o !== 8'h80 || last_o !== 1'b1 || last_bits_o !== 4'd1) begin
            n_err++; $display("FAIL bp_tail: got vld %b data %h last %b bits %0d want 1 80 1 1",
                              vld_o, data_o, last_o, last_bits_o);
        end
        tick();
        n_vec++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL bp_idle: got %b want 1", idle_o); end
    endtask

    task automatic test_flush_run();
        rdy_i = 1'b1; vld_i = 1'b1; is_one_i = 1'b0; flush_i = 1'b1; bypass_i = 1'b0;
        #1;
        n_vec++; if (rdy_o !== 1'b1) begin n_err++; $display("FAIL fr_rdy_idle: got %b want 1", rdy_o); end
        tick();
        vld_i = 1'b0; flush_i = 1'b0;
        #1;
        n_vec++; if (vld_o !== 1'b0 || rdy_o !== 1'b0) begin
            n_err++; $display("FAIL fr_run_cycle: got vld %b rdy %b want 0 0", vld_o, rdy_o);
        end
        tick();
        n_vec++; if (vld_o !== 1'b1 || data_o !== 8'h00 || last_o !== 1'b1 || last_bits_o !== 4'd3 || rdy_o !== 1'b0) begin
            n_err++; $display("FAIL fr_word: got vld %b data %h last %b bits %0d rdy %b want 1 00 1 3 0",
                              vld_o, data_o, last_o, last_bits_o, rdy_o);
        end
        tick();
        n_vec++; if (idle_o !== 1'b1 || vld_o !== 1'b0) begin
            n_err++; $display("FAIL fr_idle: got idle %b vld %b want 1 0", idle_o, vld_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] pat;
        pat = 6'b100111;   // symbols 1,1,1,0,0,1 from bit 0 upwards
        rdy_i = 1'b1; bypass_i = 1'b0; flush_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vld_i = 1'b1; is_one_i = pat[i];
            #1;
            n_vec++; if (vld_o !== 1'b0) begin n_err++; $display("FAIL rm_vld%0d: got %b want 0", i, vld_o); end
            tick();
        end
        vld_i = 1'b0;
        rst_ni = 1'b0;
        #2;
        n_vec++; if (vld_o !== 1'b0 || data_o !== 8'h00 || idle_o !== 1'b1) begin
            n_err++; $display("FAIL rm_in_reset: got vld %b data %h idle %b want 0 00 1", vld_o, data_o, idle_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        n_vec++; if (vld_o !== 1'b0 || idle_o !== 1'b1) begin
            n_err++; $display("FAIL rm_after: got vld %b idle %b want 0 1", vld_o, idle_o);
        end
        sym_q = '{1'b1};
        run_stream(1'b0, 0, 0);
        n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL rm_words: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_vec++; if (got_q[0].data !== 8'h80 || got_q[0].last !== 1'b1 || got_q[0].bits !== 4'd1) begin
                n_err++; $display("FAIL rm_word: got %h/%b/%0d want 80/1/1", got_q[0].data, got_q[0].last, got_q[0].bits);
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 60; s++) begin
            int len;
            int p1;
            int gap;
            int stall;
            bit byp;
            len   = $urandom_range(1, 40);
            p1    = $urandom_range(5, 95);
            byp   = ($urandom_range(3) == 0);
            gap   = (s % 4 == 0) ? 0 : $urandom_range(0, 40);
            stall = (s % 4 == 0) ? 0 : $urandom_range(0, 50);
            sym_q.delete();
            for (int i = 0; i < len; i++) sym_q.push_back($urandom_range(99) < p1);
            build_model(byp);
            run_stream(byp, gap, stall);
            n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rnd%0d_timeout: stream did not end", s); end
            n_vec++; if (hold_viol != 0) begin n_err++; $display("FAIL rnd%0d_hold: got %0d unstable stalls want 0", s, hold_viol); end
            n_vec++; if (got_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL rnd%0d_words: got %0d want %0d", s, got_q.size(), exp_q.size());
            end
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
                n_vec++; if (got_q[k].data !== exp_q[k].data || got_q[k].last !== exp_q[k].last ||
                             got_q[k].bits !== exp_q[k].bits) begin
                    n_err++; $display("FAIL rnd%0d_w%0d: got %h/%b/%0d want %h/%b/%0d", s, k,
                                      got_q[k].data, got_q[k].last, got_q[k].bits,
                                      exp_q[k].data, exp_q[k].last, exp_q[k].bits);
                end
            end
            n_vec++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL rnd%0d_idle: got %b want 1", s, idle_o); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_run();
        test_bypass();
        test_backpressure();
        test_flush_run();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
